dpram_data_arbiter: RTL and testbench

DPRAM_DATA_ARBITER -- requirements
Module: dpram_data_arbiter

---
 rtl/dpram_data_arbiter.sv | 122 ++++++++++++
 tb/tb_dpram_data_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_data_arbiter.sv
// Two-client arbiter in front of a single-port-pair data RAM.
// Round-robin grant with lock ownership and a 1-deep response tag.
module dpram_data_arbiter #(
  parameter int LSU_ADDR_WIDTH = 56,
  parameter int LSU_DATA_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    req_valid,
  output logic [1:0]                    req_ready,
  input  logic [1:0]                    req_store,
  input  logic [1:0]                    req_lock,
  input  logic [2*LSU_ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*LSU_DATA_WIDTH-1:0]   req_wdata,
  input  logic [2*LSU_DATA_WIDTH/8-1:0] req_wmask,
  input  logic [3:0]                    req_size,
  input  logic [1:0]                    req_unsign,
  output logic [1:0]                    resp_valid,
  output logic [LSU_DATA_WIDTH-1:0]     resp_data,
  output logic [LSU_DATA_WIDTH/8-1:0]   ram_we,
  output logic [LSU_DATA_WIDTH-1:0]     ram_din,
  output logic [LSU_ADDR_WIDTH-1:0]     ram_waddr,
  output logic [LSU_ADDR_WIDTH-1:0]     ram_raddr,
  output logic [1:0]                    ram_rsize,
  output logic                          ram_unsign,
  input  logic [LSU_DATA_WIDTH-1:0]     ram_dout
);

  localparam int AW = LSU_ADDR_WIDTH;
  localparam int DW = LSU_DATA_WIDTH;
  localparam int MW = LSU_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   tag_v_q, tag_v_d;
  logic   tag_id_q, tag_id_d;
  logic   tag_st_q, tag_st_d;
  logic   sel;
  logic   xfer;
  logic   st;

  always_comb begin
    sel       = 1'b0;
    req_ready = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (req_valid[0] && req_valid[1]) sel = ~last_q;
        else                              sel = req_valid[1];
        if (|req_valid) req_ready = sel ? 2'b10 : 2'b01;
      end
      OWN0: begin
        sel       = 1'b0;
        req_ready = 2'b01;
      end
      OWN1: begin
        sel       = 1'b1;
        req_ready = 2'b10;
      end
      default: begin
        sel       = 1'b0;
        req_ready = 2'b00;
      end
    endcase
    if (!rst) req_ready = 2'b00;
  end

  assign xfer = |(req_valid & req_ready);
  assign st   = sel ? req_store[1] : req_store[0];

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    tag_v_d  = xfer;
    tag_id_d = sel;
    tag_st_d = st;
    if (xfer) begin
      last_d = sel;
      if (sel ? req_lock[1] : req_lock[0])
        state_d = sel ? OWN1 : OWN0;
      else
        state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      tag_v_q  <= 1'b0;
      tag_id_q <= 1'b0;
      tag_st_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      tag_v_q  <= tag_v_d;
      tag_id_q <= tag_id_d;
      tag_st_q <= tag_st_d;
    end
  end

  // RAM address/data follow the selected client; only the write enable is qualified
  assign ram_waddr  = sel ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
  assign ram_raddr  = ram_waddr;
  assign ram_din    = sel ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
  assign ram_rsize  = sel ? req_size[3:2] : req_size[1:0];
  assign ram_unsign = sel ? req_unsign[1] : req_unsign[0];
  assign ram_we     = (xfer && st)
                    ? (sel ? req_wmask[2*MW-1:MW] : req_wmask[MW-1:0])
                    : '0;

  assign resp_valid = (tag_v_q && rst)
                    ? (tag_id_q ? 2'b10 : 2'b01)
                    : 2'b00;
  assign resp_data  = (tag_v_q && rst && !tag_st_q) ? ram_dout : '0;

endmodule

// File: tb/tb_dpram_data_arbiter.sv
// Bench for dpram_data_arbiter: behavioural RAM, response scoreboard
// and directed grant/ownership/reset scenarios.
module tb_dpram_data_arbiter;

  logic         clk;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req_store;
  logic [1:0]   req_lock;
  logic [111:0] req_addr;
  logic [127:0] req_wdata;
  logic [15:0]  req_wmask;
  logic [3:0]   req_size;
  logic [1:0]   req_unsign;
  logic [1:0]   resp_valid;
  logic [63:0]  resp_data;
  logic [7:0]   ram_we;
  logic [63:0]  ram_din;
  logic [55:0]  ram_waddr;
  logic [55:0]  ram_raddr;
  logic [1:0]   ram_rsize;
  logic         ram_unsign;
  logic [63:0]  ram_dout;

  int total = 0;
  int bad   = 0;

  dpram_data_arbiter #(
    .LSU_ADDR_WIDTH(56),
    .LSU_DATA_WIDTH(64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_store (req_store),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .req_size  (req_size),
    .req_unsign(req_unsign),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .ram_we    (ram_we),
    .ram_din   (ram_din),
    .ram_waddr (ram_waddr),
    .ram_raddr (ram_raddr),
    .ram_rsize (ram_rsize),
    .ram_unsign(ram_unsign),
    .ram_dout  (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int i);
    return 64'h0123_4567_89AB_CDEF ^ (64'(i) * 64'h9E37_79B9_7F4A_7C15);
  endfunction

  function automatic logic [63:0] ext(input logic [63:0] w,
                                     input logic [2:0] off,
                                     input logic [1:0] sz,
                                     input logic u);
    logic [63:0] s;
    s = w >> {off, 3'b000};
    case (sz)
      2'd0:    return u ? {56'd0, s[7:0]}  : {{56{s[7]}}, s[7:0]};
      2'd1:    return u ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
      2'd2:    return u ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
      default: return s;
    endcase
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old,
                                       input logic [63:0] d,
                                       input logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++)
      if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // Behavioural RAM: 1-cycle registered read, byte-enabled write
  logic [63:0]   mem [1024];
  logic [1023:0] mem_wr = '0;

  function automatic logic [63:0] mrd(input logic [9:0] i);
    return mem_wr[i] ? mem[i] : pat(int'(i));
  endfunction

  always @(posedge clk) begin
    if (ram_we != 8'h00) begin
      mem[ram_waddr[12:3]]    <= merge(mrd(ram_waddr[12:3]), ram_din, ram_we);
      mem_wr[ram_waddr[12:3]] <= 1'b1;
    end
    ram_dout <= ext(mrd(ram_raddr[12:3]), ram_raddr[2:0], ram_rsize, ram_unsign);
  end

  // Reference memory tracked from observed transfers
  logic [63:0]   refm [1024];
  logic [1023:0] ref_wr = '0;

  function automatic logic [63:0] rrd(input logic [9:0] i);
    return ref_wr[i] ? refm[i] : pat(int'(i));
  endfunction

  logic [64:0] sb [$];
  logic [64:0] e;
  logic [1:0]  g;
  logic        c;
  logic [55:0] a;

  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      chk("rst_resp", 64'(resp_valid), 64'd0);
    end else begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("resp_v", 64'(resp_valid), e[64] ? 64'd2 : 64'd1);
        chk("resp_d", resp_data, e[63:0]);
      end else begin
        chk("resp_idle", 64'(resp_valid), 64'd0);
      end
      g = req_valid & req_ready;
      if (g != 2'b00) begin
        c = g[1];
        a = c ? req_addr[111:56] : req_addr[55:0];
        if (req_store[c]) begin
          refm[a[12:3]]   <= merge(rrd(a[12:3]),
                                   c ? req_wdata[127:64] : req_wdata[63:0],
                                   c ? req_wmask[15:8] : req_wmask[7:0]);
          ref_wr[a[12:3]] <= 1'b1;
          sb.push_back({c, 64'd0});
        end else begin
          sb.push_back({c, ext(rrd(a[12:3]), a[2:0],
                               c ? req_size[3:2] : req_size[1:0],
                               req_unsign[c])});
        end
      end
    end
  end

  task automatic drv(input int cl, input bit v, input bit st, input bit lk,
                     input logic [55:0] ad, input logic [63:0] d,
                     input logic [7:0] m, input logic [1:0] sz,
                     input bit u);
    if (cl == 0) begin
      req_valid[0]     = v;
      req_store[0]     = st;
      req_lock[0]      = lk;
      req_addr[55:0]   = ad;
      req_wdata[63:0]  = d;
      req_wmask[7:0]   = m;
      req_size[1:0]    = sz;
      req_unsign[0]    = u;
    end else begin
      req_valid[1]     = v;
      req_store[1]     = st;
      req_lock[1]      = lk;
      req_addr[111:56] = ad;
      req_wdata[127:64] = d;
      req_wmask[15:8]  = m;
      req_size[3:2]    = sz;
      req_unsign[1]    = u;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input int cl, input bit lk, input logic [55:0] ad,
                    input logic [1:0] sz, input bit u);
    drv(cl, 1'b1, 1'b0, lk, ad, 64'd0, 8'h00, sz, u);
  endtask

  task automatic idle(input int cl);
    drv(cl, 1'b0, 1'b0, 1'b0, 56'd0, 64'd0, 8'h00, 2'd3, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    idle(0);
    idle(1);
    ld(0, 1'b0, 56'h1000, 2'd3, 1'b0);
    ld(1, 1'b0, 56'h1040, 2'd3, 1'b0);
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_we", 64'(ram_we), 64'd0);
    step();
    step();
    rst = 1'b1;

    // Alternating grants under a sustained tie
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_order", 64'(req_ready), (k % 2) ? 64'd2 : 64'd1);
      step();
    end
    idle(0);
    idle(1);
    step();

    // Masked store then word load, zero-extended
    drv(0, 1'b1, 1'b1, 1'b0, 56'h2000, 64'h1122334455667788, 8'h0F, 2'd3, 1'b0);
    @(negedge clk);
    chk("st_we", 64'(ram_we), 64'h0F);
    chk("st_addr", 64'(ram_waddr), 64'h2000);
    chk("st_din", ram_din, 64'h1122334455667788);
    step();
    ld(0, 1'b0, 56'h2000, 2'd2, 1'b1);
    @(negedge clk);
    chk("ld_we", 64'(ram_we), 64'd0);
    chk("wack_d", resp_data, 64'd0);
    step();
    idle(0);
    @(negedge clk);
    chk("ld_word", resp_data, 64'h0000000055667788);
    step();

    // Byte load, signed then unsigned
    drv(0, 1'b1, 1'b1, 1'b0, 56'h3000, 64'h80, 8'h01, 2'd3, 1'b0);
    step();
    ld(0, 1'b0, 56'h3000, 2'd0, 1'b0);
    step();
    ld(0, 1'b0, 56'h3000, 2'd0, 1'b1);
    @(negedge clk);
    chk("ld_sbyte", resp_data, 64'hFFFFFFFFFFFFFF80);
    step();
    idle(0);
    @(negedge clk);
    chk("ld_ubyte", resp_data, 64'h80);
    step();

    // Locked owner blocks the other client
    ld(0, 1'b0, 56'h1000, 2'd3, 1'b0);
    ld(1, 1'b1, 56'h1040, 2'd3, 1'b0);
    @(negedge clk);
    chk("lk_grant", 64'(req_ready), 64'd2);
    step();
    idle(1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("own1_block", 64'(req_ready[0]), 64'd0);
      step();
    end
    drv(1, 1'b1, 1'b1, 1'b0, 56'h1048, 64'hDEADBEEFCAFEF00D, 8'hFF, 2'd3, 1'b0);
    @(negedge clk);
    chk("unlk_st", 64'(req_ready), 64'd2);
    step();
    idle(1);
    @(negedge clk);
    chk("rel_grant", 64'(req_ready), 64'd1);
    step();
    idle(0);
    step();

    // Reset with a load in flight while client 0 holds the lock
    ld(0, 1'b1, 56'h1000, 2'd3, 1'b0);
    @(negedge clk);
    chk("pre_rst", 64'(req_ready), 64'd1);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rv", 64'(resp_valid), 64'd0);
    chk("rst_rdy", 64'(req_ready), 64'd0);
    step();
    rst = 1'b1;
    idle(0);
    ld(1, 1'b0, 56'h1040, 2'd3, 1'b0);
    @(negedge clk);
    chk("post_idle", 64'(req_ready), 64'd2);
    chk("post_rv", 64'(resp_valid), 64'd0);
    step();
    ld(0, 1'b0, 56'h1000, 2'd3, 1'b0);
    @(negedge clk);
    chk("post_tie", 64'(req_ready), 64'd1);
    step();
    idle(0);
    idle(1);
    step();
    step();
    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
